// File: rtl/sd_pkg.sv
// sd_pkg: register offsets, STATUS bit positions, FSM encodings and STATUS packing for sd_sector_buffer
package sd_pkg;
  localparam logic [9:0] ADDR_CTRL   = 10'h200;
  localparam logic [9:0] ADDR_SECTOR = 10'h204;
  localparam logic [9:0] ADDR_STATUS = 10'h208;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_SHORT   = 3;
  localparam int STAT_CNT_LSB = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  function automatic logic [31:0] status_word(input logic busy, input logic done, input logic tmo,
                                              input logic shrt, input logic [9:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_BUSY] = busy;
    w[STAT_DONE] = done;
    w[STAT_TIMEOUT] = tmo;
    w[STAT_SHORT] = shrt;
    w[STAT_CNT_LSB +: 10] = cnt;
    return w;
  endfunction
endpackage

// File: rtl/sd_buf_ram.sv
// sd_buf_ram: 128x32 sector buffer, byte-lane write port, 1-cycle registered read port
//   clk, we_i[3:0]/waddr_i/wdata_i: lane write; re_i/raddr_i: read request; rdata_o: data one cycle later
module sd_buf_ram (
  input  logic        clk,
  input  logic [3:0]  we_i,
  input  logic [6:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        re_i,
  input  logic [6:0]  raddr_i,
  output logic [31:0] rdata_o
);
  logic [31:0] mem_q [128];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/sd_sector_buffer.sv
// sd_sector_buffer: CPU-mapped sector buffer filled byte-by-byte from a slow-domain SPI sector reader
//   cpu_addr/cpu_we/cpu_re/cpu_wdata -> cpu_rdata/cpu_ready: 1 KB window (buffer, CTRL, SECTOR, STATUS)
//   sd_sector_addr/sd_rd_trigger: request to the reader; sd_data/sd_valid/sd_busy: reader byte stream
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic [31:0] sd_sector_addr,
  output logic        sd_rd_trigger,
  input  logic [7:0]  sd_data,
  input  logic        sd_valid,
  input  logic        sd_busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [9:0] FULL = 10'(SECTOR_BYTES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  logic [2:0] vsync_q, state_q, state_d;
  logic [1:0] bsync_q;
  logic trig_q, trig_d, done_q, done_d, to_q, to_d, short_q, short_d;
  logic [9:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, sector_q, csr_q, ram_rdata, status;
  logic [TW-1:0] tmo_q, tmo_d;
  logic ready_q, buf_sel_q, v_edge, busy_s, expire, is_ctrl, is_sector, is_status, start;
  logic [3:0] ram_we;
  logic unused_ok;
  // vsync_q[2] is the previous synchronized sample, so v_edge is a clean one-cycle pulse
  assign v_edge = vsync_q[1] & ~vsync_q[2];
  assign busy_s = bsync_q[1];
  assign expire = tmo_q == TLAST;
  assign is_ctrl = cpu_addr[9:2] == ADDR_CTRL[9:2];
  assign is_sector = cpu_addr[9:2] == ADDR_SECTOR[9:2];
  assign is_status = cpu_addr[9:2] == ADDR_STATUS[9:2];
  assign start = cpu_we & is_ctrl & cpu_wdata[0];
  assign status = status_word(state_q != S_IDLE, done_q, to_q, short_q, cnt_q);
  assign unused_ok = ^cpu_addr[1:0];
  assign cpu_ready = ready_q;
  assign cpu_rdata = buf_sel_q ? ram_rdata : csr_q;
  assign sd_sector_addr = addr_q;
  assign sd_rd_trigger = trig_q;
  always_comb begin
    state_d = state_q;
    trig_d = trig_q;
    done_d = done_q;
    to_d = to_q;
    short_d = short_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    ram_we = 4'b0000;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_REQ;
        trig_d = 1'b1;
        done_d = 1'b0;
        to_d = 1'b0;
        short_d = 1'b0;
        cnt_d = '0;
        addr_d = sector_q;
      end
      S_REQ: begin
        state_d = busy_s ? S_RECV : expire ? S_ERR : S_REQ;
        trig_d = !busy_s && !expire;
        to_d = !busy_s && expire;
      end
      S_RECV: begin
        if (v_edge) begin
          ram_we = 4'b0001 << cnt_q[1:0];
          cnt_d = cnt_q + 10'd1;
        end
        // a byte arriving alongside busy falling still counts before the short check
        state_d = cnt_d == FULL ? S_DRAIN : !busy_s ? S_IDLE : (expire && !v_edge) ? S_ERR : S_RECV;
        short_d = cnt_d != FULL && !busy_s;
        to_d = cnt_d != FULL && busy_s && expire && !v_edge;
      end
      S_DRAIN: begin
        state_d = !busy_s ? S_IDLE : (expire && !v_edge) ? S_ERR : S_DRAIN;
        done_d = !busy_s;
        to_d = busy_s && expire && !v_edge;
      end
      S_ERR: state_d = busy_s ? S_ERR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tmo_d = (state_d != state_q || v_edge || state_q == S_IDLE) ? '0 : tmo_q + TW'(1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= '0;
      bsync_q <= '0;
      state_q <= S_IDLE;
      trig_q <= 1'b0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      short_q <= 1'b0;
      cnt_q <= '0;
      addr_q <= '0;
      tmo_q <= '0;
      sector_q <= '0;
      csr_q <= '0;
      ready_q <= 1'b0;
      buf_sel_q <= 1'b0;
    end else begin
      vsync_q <= {vsync_q[1:0], sd_valid};
      bsync_q <= {bsync_q[0], sd_busy};
      state_q <= state_d;
      trig_q <= trig_d;
      done_q <= done_d;
      to_q <= to_d;
      short_q <= short_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      tmo_q <= tmo_d;
      ready_q <= cpu_re | cpu_we;
      if (cpu_we && is_sector && state_q == S_IDLE) sector_q <= cpu_wdata;
      if (cpu_re) begin
        buf_sel_q <= ~cpu_addr[9];
        csr_q <= is_sector ? sector_q : is_status ? status : '0;
      end
    end
  end
  sd_buf_ram u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(cnt_q[8:2]),
    .wdata_i({4{sd_data}}),
    .re_i   (cpu_re & ~cpu_addr[9]),
    .raddr_i(cpu_addr[8:2]),
    .rdata_o(ram_rdata)
  );
endmodule
